// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster/sync generator with LOOKAHEAD-aligned pixel pipeline (clk/rst/pix_ce in, req_* fetch port, pixel_in -> pixel_out/hsync/vsync/active/line_start/frame_start)
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int PIX_W = 12,
  parameter logic [PIX_W-1:0] BLANK_COLOR = '0,
  parameter int LOOKAHEAD = 1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W = $clog2(H_TOTAL),
  localparam int Y_W = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  output logic [X_W-1:0]   req_x,
  output logic [Y_W-1:0]   req_y,
  output logic             req_valid,
  input  logic [PIX_W-1:0] pixel_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start
);
  if (LOOKAHEAD < 0 || LOOKAHEAD > 4 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIX_W < 1) begin : g_bad_params
    $error("vga_timing_gen: illegal parameters");
  end
  localparam int PD = (LOOKAHEAD > 0) ? LOOKAHEAD : 1;
  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] HA = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_B = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_E = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] VA = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_B = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_E = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  logic [X_W-1:0] hc_q, hc_d;
  logic [Y_W-1:0] vc_q, vc_d;
  logic hs_raw, vs_raw;
  logic [4:0] tap, last;
  logic [PD*5-1:0] pipe_q, pipe_d;
  logic [(PD+1)*5-1:0] shift;
  logic hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  always_comb begin
    hc_d = !pix_ce ? hc_q : (hc_q == H_LAST) ? '0 : hc_q + X_W'(1);
    vc_d = !(pix_ce && hc_q == H_LAST) ? vc_q : (vc_q == V_LAST) ? '0 : vc_q + Y_W'(1);
    req_valid = (hc_q < HA) && (vc_q < VA);
    hs_raw = (hc_q >= HS_B) && (hc_q < HS_E);
    vs_raw = (vc_q >= VS_B) && (vc_q < VS_E);
    tap = {hs_raw, vs_raw, req_valid, hc_q == '0, hc_q == '0 && vc_q == '0};
    // shift[4:0] is the current position, shift[5*k +: 5] the one requested k ticks ago
    shift = {pipe_q, tap};
    pipe_d = pix_ce ? shift[PD*5-1:0] : pipe_q;
    last = shift[LOOKAHEAD*5 +: 5];
    hsync_d = pix_ce ? last[4] ^ ~HS_POL : hsync_q;
    vsync_d = pix_ce ? last[3] ^ ~VS_POL : vsync_q;
    active_d = pix_ce ? last[2] : active_q;
    line_start_d = pix_ce & last[1];
    frame_start_d = pix_ce & last[0];
    pixel_d = !pix_ce ? pixel_q : last[2] ? pixel_in : BLANK_COLOR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
      pipe_q <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      active_q <= 1'b0;
      line_start_q <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_q <= BLANK_COLOR;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      pipe_q <= pipe_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      active_q <= active_d;
      line_start_q <= line_start_d;
      frame_start_q <= frame_start_d;
      pixel_q <= pixel_d;
    end
  end
  assign req_x = hc_q;
  assign req_y = vc_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign active = active_q;
  assign line_start = line_start_q;
  assign frame_start = frame_start_q;
  assign pixel_out = pixel_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three parameterisations checked every clk against a position-arithmetic reference model
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst, pix_ce;
  always #5 clk = ~clk;
  logic [9:0] req_x0;
  logic [4:0] req_y0;
  logic [3:0] req_x1, req_x2;
  logic [2:0] req_y1, req_y2;
  logic req_valid0, req_valid1, req_valid2;
  logic [11:0] pixel_in0, pixel_in1, pixel_in2, pixel_out0, pixel_out1, pixel_out2;
  logic hsync0, hsync1, hsync2, vsync0, vsync1, vsync2, active0, active1, active2;
  logic line_start0, line_start1, line_start2, frame_start0, frame_start1, frame_start2;
  logic [11:0] s0, s1a, s1b;
  vga_timing_gen #(.V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u0 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .req_x(req_x0), .req_y(req_y0), .req_valid(req_valid0),
    .pixel_in(pixel_in0), .pixel_out(pixel_out0), .hsync(hsync0), .vsync(vsync0), .active(active0),
    .line_start(line_start0), .frame_start(frame_start0));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOOKAHEAD(2), .BLANK_COLOR(12'h5A5)) u1 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .req_x(req_x1), .req_y(req_y1), .req_valid(req_valid1),
    .pixel_in(pixel_in1), .pixel_out(pixel_out1), .hsync(hsync1), .vsync(vsync1), .active(active1),
    .line_start(line_start1), .frame_start(frame_start1));
  vga_timing_gen #(.H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b0), .LOOKAHEAD(0), .BLANK_COLOR(12'h00F)) u2 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .req_x(req_x2), .req_y(req_y2), .req_valid(req_valid2),
    .pixel_in(pixel_in2), .pixel_out(pixel_out2), .hsync(hsync2), .vsync(vsync2), .active(active2),
    .line_start(line_start2), .frame_start(frame_start2));
  // pixel sources: colour = {x[5:0], y[5:0]} of the request, delayed by each instance's read latency
  always @(posedge clk) begin
    if (rst) begin
      s0 <= '0;
      s1a <= '0;
      s1b <= '0;
    end else if (pix_ce) begin
      s0 <= {6'(req_x0), 6'(req_y0)};
      s1a <= {6'(req_x1), 6'(req_y1)};
      s1b <= s1a;
    end
  end
  assign pixel_in0 = s0;
  assign pixel_in1 = s1b;
  assign pixel_in2 = {6'(req_x2), 6'(req_y2)};
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n = 0, cyc = 0, l0 = -1, l1 = -1, l2 = -1, per_mul = 1;
  bit lastce = 1'b0, per_on = 1'b0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // n = pix_ce ticks since reset; output for tick index n-1 shows the position requested LOOKAHEAD ticks earlier
  task automatic verify(string nm, int ha, int hf, int hsw, int hb, int va, int vf, int vsw, int vb,
                        bit hp, bit vp, int la, logic [11:0] blank, logic [16:0] o_out, logic [20:0] o_req);
    int ht, vt, k, x, y, rx, ry;
    logic a;
    logic [16:0] e_out;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    k = n - 1 - la;
    if (k < 0) e_out = {!hp, !vp, 3'b000, blank};
    else begin
      x = k % ht;
      y = (k / ht) % vt;
      a = x < ha && y < va;
      e_out = {(x >= ha + hf && x < ha + hf + hsw) ? hp : !hp, (y >= va + vf && y < va + vf + vsw) ? vp : !vp,
               a, lastce && x == 0, lastce && x == 0 && y == 0, a ? {6'(x), 6'(y)} : blank};
    end
    rx = n % ht;
    ry = (n / ht) % vt;
    chk({nm, "_out"}, 32'(o_out), 32'(e_out));
    chk({nm, "_req"}, 32'(o_req), 32'({rx < ha && ry < va, 10'(ry), 10'(rx)}));
  endtask
  task automatic tick(bit r, bit c);
    rst = r;
    pix_ce = c;
    @(posedge clk);
    #1;
    cyc++;
    lastce = c && !r;
    n = r ? 0 : n + int'(c);
    verify("u0", 640, 16, 96, 48, 12, 2, 2, 3, 1'b0, 1'b0, 1, 12'h000,
           {hsync0, vsync0, active0, line_start0, frame_start0, pixel_out0}, {req_valid0, 10'(req_y0), 10'(req_x0)});
    verify("u1", 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2, 12'h5A5,
           {hsync1, vsync1, active1, line_start1, frame_start1, pixel_out1}, {req_valid1, 10'(req_y1), 10'(req_x1)});
    verify("u2", 5, 1, 2, 1, 3, 1, 1, 2, 1'b1, 1'b0, 0, 12'h00F,
           {hsync2, vsync2, active2, line_start2, frame_start2, pixel_out2}, {req_valid2, 10'(req_y2), 10'(req_x2)});
    if (r || !per_on) begin
      l0 = -1;
      l1 = -1;
      l2 = -1;
    end else begin
      if (line_start0) begin
        if (l0 >= 0) chk("ls_period_u0", 32'(cyc - l0), 32'(per_mul * 800));
        l0 = cyc;
      end
      if (frame_start1) begin
        if (l1 >= 0) chk("fs_period_u1", 32'(cyc - l1), 32'(per_mul * 98));
        l1 = cyc;
      end
      if (frame_start0) begin
        if (l2 >= 0) chk("fs_period_u0", 32'(cyc - l2), 32'(per_mul * 15200));
        l2 = cyc;
      end
    end
  endtask
  initial begin
    bit found;
    int got;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    per_on = 1'b1;
    per_mul = 1;
    for (int i = 0; i < 16000; i++) tick(1'b0, 1'b1);
    per_on = 1'b0;
    for (int i = 0; i < 8000; i++) tick(1'b0, 1'($urandom_range(0, 1)));
    tick(1'b0, 1'b0);
    per_on = 1'b1;
    per_mul = 2;
    for (int i = 0; i < 3400; i++) tick(1'b0, 1'(i & 1));
    per_on = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick(1'b0, 1'($urandom_range(0, 3) != 0));
      found = (req_y0 == 5'd5 && req_x0 == 10'd300);
    end
    chk("reach_mid_frame", 32'(found), 32'd1);
    tick(1'b1, 1'b1);
    got = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b1);
      if (frame_start0) begin
        got = i;
        break;
      end
    end
    chk("fs_after_rst_u0", 32'(got), 32'd2);
    per_on = 1'b1;
    per_mul = 1;
    for (int i = 0; i < 16000; i++) tick(1'b0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
